// File: rtl/rom_bus_ctrl.sv
`timescale 1ns/1ps
// rom_bus_ctrl: Z80-side controller for two 8K pROMs. Decodes ROM reads in
// 0x0000-0x3FFF, holds the CPU in WAIT for the ROM latency, then drives
// the selected ROM onto the data bus until the CPU drops its strobes.
// Writes into ROM space raise a sticky error flag. Every output is a flop.
module rom_bus_ctrl #(
  parameter int unsigned LATENCY = 2   // pROM read latency, legal range 1..3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] a,
  input  logic        clear_err,
  output logic        ce_0,
  output logic        ce_1,
  output logic        oce,
  output logic [12:0] ad,
  output logic        wait_n,
  output logic        wr_err,
  output logic [15:0] rd_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRIVE  = 2'd2
  } state_e;

  // Counter load value: the counter reaches zero on the cycle the data is
  // valid, so DRIVE is entered exactly LATENCY edges after the request.
  localparam logic [1:0] LAT_INIT = 2'(LATENCY - 1);

  state_e      state_q, state_d;
  logic        ce_0_q, ce_0_d;
  logic        ce_1_q, ce_1_d;
  logic        oce_q, oce_d;
  logic [12:0] ad_q, ad_d;
  logic        wait_n_q, wait_n_d;
  logic        wr_err_q, wr_err_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;

  logic rom_space;
  logic rd_req;
  logic wr_viol;
  logic rd_release;

  // Bus decode: ROM occupies the bottom 16K of the address map.
  always_comb begin
    rom_space  = (a[15:14] == 2'b00);
    rd_req     = ~mreq_n & ~rd_n & wr_n & rom_space;
    wr_viol    = ~mreq_n & ~wr_n & rom_space;
    rd_release = mreq_n | rd_n;
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    // NOTE: every _d signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    ce_0_d     = ce_0_q;
    ce_1_d     = ce_1_q;
    oce_d      = oce_q;
    ad_d       = ad_q;
    wait_n_d   = wait_n_q;
    rd_count_d = rd_count_q;
    lat_cnt_d  = lat_cnt_q;
    // A clear pulse drops the flag unless a new violation lands this cycle.
    wr_err_d   = clear_err ? 1'b0 : wr_err_q;

    unique case (state_q)
      IDLE: begin
        if (wr_viol) begin
          // Write into ROM space (even with rd_n also low) never starts a read.
          wr_err_d = 1'b1;
        end else if (rd_req) begin
          ad_d      = a[12:0];
          ce_0_d    = ~a[13];
          ce_1_d    = a[13];
          wait_n_d  = 1'b0;
          lat_cnt_d = LAT_INIT;
          state_d   = ACCESS;
        end
      end

      ACCESS: begin
        if (rd_release) begin
          // CPU abandoned the cycle before data was ready: not a completed read.
          ce_0_d   = 1'b0;
          ce_1_d   = 1'b0;
          wait_n_d = 1'b1;
          state_d  = IDLE;
        end else if (lat_cnt_q == 2'd0) begin
          oce_d    = 1'b1;
          wait_n_d = 1'b1;
          state_d  = DRIVE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      DRIVE: begin
        // Address and enables stay frozen; only the strobe release matters.
        if (rd_release) begin
          ce_0_d     = 1'b0;
          ce_1_d     = 1'b0;
          oce_d      = 1'b0;
          rd_count_d = rd_count_q + 16'd1;
          state_d    = IDLE;
        end
      end

      default: begin
        ce_0_d   = 1'b0;
        ce_1_d   = 1'b0;
        oce_d    = 1'b0;
        wait_n_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides every event.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      ce_0_q     <= 1'b0;
      ce_1_q     <= 1'b0;
      oce_q      <= 1'b0;
      ad_q       <= 13'd0;
      wait_n_q   <= 1'b1;
      wr_err_q   <= 1'b0;
      rd_count_q <= 16'd0;
      lat_cnt_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      ce_0_q     <= ce_0_d;
      ce_1_q     <= ce_1_d;
      oce_q      <= oce_d;
      ad_q       <= ad_d;
      wait_n_q   <= wait_n_d;
      wr_err_q   <= wr_err_d;
      rd_count_q <= rd_count_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign ce_0     = ce_0_q;
  assign ce_1     = ce_1_q;
  assign oce      = oce_q;
  assign ad       = ad_q;
  assign wait_n   = wait_n_q;
  assign wr_err   = wr_err_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_rom_bus_ctrl.sv
`timescale 1ns/1ps
// tb_rom_bus_ctrl: drives three controllers (LATENCY 1, 2, 3) from one Z80
// stimulus stream. The LATENCY=2 instance gets cycle-accurate checks and a
// scoreboard of expected ROM selections; all three are checked for WAIT
// length, completed-read counts and the write-error flag.
module tb_rom_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset, mreq_n, rd_n, wr_n, clear_err;
  logic [15:0] a;

  logic        ce_0     [1:3];
  logic        ce_1     [1:3];
  logic        oce      [1:3];
  logic [12:0] ad       [1:3];
  logic        wait_n   [1:3];
  logic        wr_err   [1:3];
  logic [15:0] rd_count [1:3];

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : gen_dut
    rom_bus_ctrl #(.LATENCY(g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .mreq_n   (mreq_n),
      .rd_n     (rd_n),
      .wr_n     (wr_n),
      .a        (a),
      .clear_err(clear_err),
      .ce_0     (ce_0[g]),
      .ce_1     (ce_1[g]),
      .oce      (oce[g]),
      .ad       (ad[g]),
      .wait_n   (wait_n[g]),
      .wr_err   (wr_err[g]),
      .rd_count (rd_count[g])
    );
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of expected ROM selection for each read that should reach DRIVE
  // on the LATENCY=2 instance.
  typedef struct packed {
    logic        ce_0;
    logic        ce_1;
    logic [12:0] ad;
  } sel_t;
  sel_t sb_q[$];

  logic [15:0] exp_cnt [1:3];
  logic        exp_err;
  int          run      [1:3];
  int          last_run [1:3];
  logic        oce_prev = 1'b0;

  // Pop the scoreboard on each oce rising edge of the LATENCY=2 instance.
  always @(negedge clk) begin
    if (oce[2] && !oce_prev) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_drive", 32'd1, 32'd0);
      end else begin
        sel_t e;
        e = sb_q.pop_front();
        check_eq("sb_ce_0", {31'd0, ce_0[2]}, {31'd0, e.ce_0});
        check_eq("sb_ce_1", {31'd0, ce_1[2]}, {31'd0, e.ce_1});
        check_eq("sb_ad",   {19'd0, ad[2]},   {19'd0, e.ad});
      end
    end
    oce_prev = oce[2];
  end

  // Measure how many consecutive sampled cycles each instance held WAIT low.
  always @(negedge clk) begin
    for (int g = 1; g <= 3; g++) begin
      if (reset) begin
        run[g] = 0;
      end else if (!wait_n[g]) begin
        run[g]++;
      end else if (run[g] > 0) begin
        last_run[g] = run[g];
        run[g] = 0;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag, input int g);
    check_eq({tag, "_ce"},     {31'd0, ce_0[g] | ce_1[g]}, 32'd0);
    check_eq({tag, "_oce"},    {31'd0, oce[g]},            32'd0);
    check_eq({tag, "_wait_n"}, {31'd0, wait_n[g]},         32'd1);
  endtask

  // One Z80 read: strobes low for `hold` edges, then released.
  task automatic read_txn(input logic [15:0] addr, input int hold);
    logic rom;
    sel_t e;
    rom = (addr[15:14] == 2'b00);
    for (int g = 1; g <= 3; g++) last_run[g] = 0;
    mreq_n = 1'b0;
    rd_n   = 1'b0;
    wr_n   = 1'b1;
    a      = addr;
    if (rom && hold >= 3) begin
      e.ce_0 = ~addr[13];
      e.ce_1 = addr[13];
      e.ad   = addr[12:0];
      sb_q.push_back(e);
    end
    for (int k = 1; k <= hold; k++) begin
      cycle();
      check_eq("rd_ce_0",   {31'd0, ce_0[2]},   {31'd0, rom & ~addr[13]});
      check_eq("rd_ce_1",   {31'd0, ce_1[2]},   {31'd0, rom & addr[13]});
      check_eq("rd_wait_n", {31'd0, wait_n[2]}, {31'd0, !rom || k >= 3});
      check_eq("rd_oce",    {31'd0, oce[2]},    {31'd0, rom && k >= 3});
      if (rom && k == 1) check_eq("rd_ad", {19'd0, ad[2]}, {19'd0, addr[12:0]});
    end
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    cycle();
    for (int g = 1; g <= 3; g++) begin
      if (rom && hold >= g + 1) begin
        exp_cnt[g] = exp_cnt[g] + 16'd1;
        check_eq($sformatf("wait_len_lat%0d", g), last_run[g], g);
      end
      check_eq($sformatf("rd_count_lat%0d", g), {16'd0, rd_count[g]}, {16'd0, exp_cnt[g]});
      check_idle($sformatf("rel_lat%0d", g), g);
    end
    cycle();
  endtask

  // One Z80 write (optionally with rd_n also low and a clear_err pulse).
  task automatic wr_txn(input logic [15:0] addr, input logic rd_low, input logic clr);
    mreq_n    = 1'b0;
    wr_n      = 1'b0;
    rd_n      = ~rd_low;
    a         = addr;
    clear_err = clr;
    if (addr[15:14] == 2'b00) exp_err = 1'b1;
    else if (clr)             exp_err = 1'b0;
    cycle();
    mreq_n    = 1'b1;
    wr_n      = 1'b1;
    rd_n      = 1'b1;
    clear_err = 1'b0;
    for (int g = 1; g <= 3; g++) begin
      check_eq($sformatf("wr_err_lat%0d", g), {31'd0, wr_err[g]}, {31'd0, exp_err});
      check_idle($sformatf("wr_lat%0d", g), g);
    end
    cycle();
    check_idle("wr_after", 2);
  endtask

  task automatic clear_pulse();
    clear_err = 1'b1;
    exp_err   = 1'b0;
    cycle();
    clear_err = 1'b0;
    for (int g = 1; g <= 3; g++)
      check_eq($sformatf("clr_lat%0d", g), {31'd0, wr_err[g]}, {31'd0, exp_err});
  endtask

  initial begin
    sel_t e;
    for (int g = 1; g <= 3; g++) begin
      exp_cnt[g]  = 16'd0;
      run[g]      = 0;
      last_run[g] = 0;
    end
    exp_err   = 1'b0;
    clear_err = 1'b0;
    wr_n      = 1'b1;

    // Reset with a ROM read already asserted; the read starts once reset drops.
    reset  = 1'b1;
    mreq_n = 1'b0;
    rd_n   = 1'b0;
    a      = 16'h0055;
    @(negedge clk);
    cycle();
    check_eq("rst_ce",       {31'd0, ce_0[2] | ce_1[2]}, 32'd0);
    check_eq("rst_oce",      {31'd0, oce[2]},            32'd0);
    check_eq("rst_wait_n",   {31'd0, wait_n[2]},         32'd1);
    check_eq("rst_ad",       {19'd0, ad[2]},             32'd0);
    check_eq("rst_wr_err",   {31'd0, wr_err[2]},         32'd0);
    check_eq("rst_rd_count", {16'd0, rd_count[2]},       32'd0);
    e.ce_0 = 1'b1;
    e.ce_1 = 1'b0;
    e.ad   = 13'h0055;
    sb_q.push_back(e);
    reset = 1'b0;
    cycle();
    check_eq("held_ce_0",   {31'd0, ce_0[2]},   32'd1);
    check_eq("held_wait_n", {31'd0, wait_n[2]}, 32'd0);
    check_eq("held_ad",     {19'd0, ad[2]},     32'h55);
    repeat (4) cycle();
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    cycle();
    for (int g = 1; g <= 3; g++) begin
      exp_cnt[g] = 16'd1;
      check_eq($sformatf("held_cnt_lat%0d", g), {16'd0, rd_count[g]}, 32'd1);
    end
    cycle();

    // Reads: lower ROM, upper ROM, outside ROM, abort, minimum hold.
    read_txn(16'h1234, 6);
    read_txn(16'h2ABC, 6);
    read_txn(16'h4000, 3);
    read_txn(16'hC123, 2);
    read_txn(16'h3FFF, 2);   // aborts on LATENCY 2 and 3, completes on 1
    read_txn(16'h0000, 4);

    // Write-error flag.
    wr_txn(16'h0100, 1'b0, 1'b0);
    clear_pulse();
    wr_txn(16'h0100, 1'b1, 1'b1);   // rd_n low too, and clear in same cycle
    clear_pulse();
    wr_txn(16'h8000, 1'b0, 1'b0);   // outside ROM: no flag

    // Reset while the LATENCY=2 instance is in DRIVE.
    mreq_n = 1'b0;
    rd_n   = 1'b0;
    a      = 16'h1ABC;
    e.ce_0 = 1'b1;
    e.ce_1 = 1'b0;
    e.ad   = 13'h1ABC;
    sb_q.push_back(e);
    repeat (3) cycle();
    check_eq("pre_rst_oce", {31'd0, oce[2]}, 32'd1);
    reset = 1'b1;
    cycle();
    for (int g = 1; g <= 3; g++) begin
      exp_cnt[g] = 16'd0;
      check_idle($sformatf("drv_rst_lat%0d", g), g);
      check_eq($sformatf("drv_rst_ad_lat%0d", g), {19'd0, ad[g]}, 32'd0);
      check_eq($sformatf("drv_rst_cnt_lat%0d", g), {16'd0, rd_count[g]}, 32'd0);
    end
    reset  = 1'b0;
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    cycle();
    check_eq("post_rst_cnt", {16'd0, rd_count[2]}, 32'd0);
    check_idle("post_rst", 2);

    // Counter wrap: preload 0xFFFF on the LATENCY=2 instance, one more read.
    force gen_dut[2].u_dut.rd_count_q = 16'hFFFF;
    #1;
    release gen_dut[2].u_dut.rd_count_q;
    exp_cnt[2] = 16'hFFFF;
    @(negedge clk);
    read_txn(16'h0ABC, 6);
    check_eq("wrap_zero", {16'd0, rd_count[2]}, 32'd0);

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
